// File: rtl/musb_mem_port_responder_pkg.sv
// rtl/musb_mem_port_responder_pkg.sv - shared FSM encodings, limits and address helper
// Imported by the memory-port responder.
package musb_mem_port_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_READ   = 3'd3,
        ST_RESP   = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

    // 33-bit span so a region covering the full 32-bit space still compares correctly.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned aw);
        logic [31:0] offset;
        logic [32:0] span;
        offset = addr - base;
        span   = 33'd1 << (aw + 2);
        return ({1'b0, offset} < span);
    endfunction

endpackage

// File: rtl/musb_mem_port_responder.sv
// rtl/musb_mem_port_responder.sv - bus-port to single-port SRAM responder with wait states
// Range check, optional wait states, one-cycle SRAM strobe, registered ready/error.
module musb_mem_port_responder
    import musb_mem_port_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           port_address,
    input  logic [31:0]           port_data_i,
    input  logic [3:0]            port_wr,
    input  logic                  port_enable,
    output logic [31:0]           port_data_o,
    output logic                  port_ready,
    output logic                  port_error,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_STATES);

    state_t                  state;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [ADDR_WIDTH-1:0]   req_word;
    logic [3:0]              req_wr;
    logic [31:0]             req_data;
    logic                    in_range;

    assign in_range = addr_in_range(port_address, BASE_ADDR, ADDR_WIDTH);

    // SRAM side is decoded from state so reset removes the strobe without a clock edge.
    assign sram_en    = (state == ST_ACCESS);
    assign sram_we    = sram_en ? req_wr   : 4'b0000;
    assign sram_addr  = sram_en ? req_word : '0;
    assign sram_wdata = sram_en ? req_data : 32'h0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            req_word    <= '0;
            req_wr      <= 4'b0000;
            req_data    <= 32'h0;
            port_data_o <= 32'h0;
            port_ready  <= 1'b0;
            port_error  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (port_enable) begin
                        req_word <= port_address[ADDR_WIDTH+1:2];
                        req_wr   <= port_wr;
                        req_data <= port_data_i;
                        wait_cnt <= WAIT_INIT;
                        if (!in_range) begin
                            state      <= ST_ERR;
                            port_error <= 1'b1;
                        end else if (WAIT_STATES > 0) begin
                            state <= ST_WAIT;
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (!port_enable) begin
                        state <= ST_IDLE;
                    end else if (wait_cnt == WAIT_CNT_W'(1)) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (req_wr != 4'b0000) begin
                        state      <= ST_RESP;
                        port_ready <= 1'b1;
                    end else begin
                        state <= ST_READ;
                    end
                end
                ST_READ: begin
                    port_data_o <= sram_rdata;
                    port_ready  <= 1'b1;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    if (!port_enable) begin
                        port_ready <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    if (!port_enable) begin
                        port_error <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_musb_mem_port_responder.sv
// tb/tb_musb_mem_port_responder.sv - scoreboard bench for the memory-port responder
module tb_musb_mem_port_responder;

    localparam logic [31:0] BASE1 = 32'h0001_0000;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] port_address = 32'h0;
    logic [31:0] port_data_i  = 32'h0;
    logic [3:0]  port_wr      = 4'b0;
    logic        port_enable  = 1'b0;
    logic        sel          = 1'b0;

    logic        en_in0, en_in1;
    logic [31:0] data_o0, data_o1, wdata0, wdata1, rdata0, rdata1;
    logic        ready0, ready1, error0, error1, sen0, sen1;
    logic [3:0]  swe0, swe1;
    logic [9:0]  saddr0, saddr1;

    logic [31:0] cur_data, cur_wdata;
    logic        cur_ready, cur_error, cur_en;
    logic [3:0]  cur_we;
    logic [9:0]  cur_saddr;

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    logic [31:0] ref_mem [2][1024];
    logic [31:0] last_rd [2];
    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          both_cnt = 0;

    always #5 clk = ~clk;

    assign en_in0 = port_enable & ~sel;
    assign en_in1 = port_enable & sel;

    musb_mem_port_responder #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .port_address(port_address), .port_data_i(port_data_i),
        .port_wr(port_wr), .port_enable(en_in0), .port_data_o(data_o0), .port_ready(ready0),
        .port_error(error0), .sram_en(sen0), .sram_we(swe0), .sram_addr(saddr0),
        .sram_wdata(wdata0), .sram_rdata(rdata0));

    musb_mem_port_responder #(.ADDR_WIDTH(10), .BASE_ADDR(BASE1), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .port_address(port_address), .port_data_i(port_data_i),
        .port_wr(port_wr), .port_enable(en_in1), .port_data_o(data_o1), .port_ready(ready1),
        .port_error(error1), .sram_en(sen1), .sram_we(swe1), .sram_addr(saddr1),
        .sram_wdata(wdata1), .sram_rdata(rdata1));

    always @(posedge clk) begin
        if (sen0) begin
            for (int b = 0; b < 4; b++)
                if (swe0[b]) mem0[saddr0][8*b +: 8] <= wdata0[8*b +: 8];
            if (swe0 == 4'b0) rdata0 <= mem0[saddr0];
        end
        if (sen1) begin
            for (int b = 0; b < 4; b++)
                if (swe1[b]) mem1[saddr1][8*b +: 8] <= wdata1[8*b +: 8];
            if (swe1 == 4'b0) rdata1 <= mem1[saddr1];
        end
    end

    always @(negedge clk)
        if ((ready0 && error0) || (ready1 && error1)) both_cnt++;

    always_comb begin
        cur_data  = sel ? data_o1 : data_o0;
        cur_ready = sel ? ready1  : ready0;
        cur_error = sel ? error1  : error0;
        cur_en    = sel ? sen1    : sen0;
        cur_we    = sel ? swe1    : swe0;
        cur_saddr = sel ? saddr1  : saddr0;
        cur_wdata = sel ? wdata1  : wdata0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge; the model predicts latency, flags and data.
    task automatic do_txn(input logic [31:0] addr, input logic [3:0] wr,
                          input logic [31:0] data, input string tag);
        int ws, exp_lat, n, acc_n, acc_cnt;
        logic [31:0] base, off, w, acc_wdata;
        logic inr;
        logic [3:0] acc_we;
        logic [9:0] acc_addr;
        exp_t e;
        ws   = sel ? 3 : 0;
        base = sel ? BASE1 : 32'h0;
        off  = addr - base;
        inr  = off < 32'h1000;
        e.err  = !inr;
        e.data = last_rd[sel];
        if (inr && wr == 4'b0) begin
            e.data = ref_mem[sel][off[11:2]];
            last_rd[sel] = e.data;
        end else if (inr) begin
            w = ref_mem[sel][off[11:2]];
            for (int b = 0; b < 4; b++) if (wr[b]) w[8*b +: 8] = data[8*b +: 8];
            ref_mem[sel][off[11:2]] = w;
        end
        exp_lat = !inr ? 1 : (wr != 4'b0 ? 2 + ws : 3 + ws);
        sb.push_back(e);

        port_address = addr; port_wr = wr; port_data_i = data; port_enable = 1'b1;
        n = 0; acc_n = 0; acc_cnt = 0; acc_we = 4'b0; acc_addr = '0; acc_wdata = 32'h0;
        while (n < 40) begin
            @(posedge clk); #1; n++;
            port_address = ~addr; port_data_i = ~data;
            if (cur_en) begin
                acc_cnt++; acc_n = n; acc_we = cur_we; acc_addr = cur_saddr; acc_wdata = cur_wdata;
            end
            if (cur_ready || cur_error) break;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, n, exp_lat);
        chk({tag, " error"}, {31'b0, cur_error}, {31'b0, e.err});
        chk({tag, " ready"}, {31'b0, cur_ready}, {31'b0, !e.err});
        chk({tag, " data_o"}, cur_data, e.data);
        chk({tag, " sram strobes"}, acc_cnt, inr ? 1 : 0);
        if (inr) begin
            chk({tag, " access edge"}, acc_n, 1 + ws);
            chk({tag, " sram_we"}, {28'b0, acc_we}, {28'b0, wr});
            chk({tag, " sram_addr"}, {22'b0, acc_addr}, {22'b0, off[11:2]});
            if (wr != 4'b0) chk({tag, " sram_wdata"}, acc_wdata, data);
        end
        @(posedge clk); #1;
        chk({tag, " hold flags"}, {30'b0, cur_ready, cur_error}, {30'b0, !e.err, e.err});
        chk({tag, " hold data"}, cur_data, e.data);
        @(negedge clk); port_enable = 1'b0;
        @(posedge clk); #1;
        chk({tag, " flags cleared"}, {30'b0, cur_ready, cur_error}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  m;
        int          strobes;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[0][i] = 32'h0;
            ref_mem[1][i] = 32'h0;
        end
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;

        #1 rst = 1'b0;
        #2;
        chk("reset dut0 outputs", {data_o0[31:2], ready0, error0}, 32'h0);
        chk("reset dut0 sram", {27'b0, sen0, swe0}, 32'h0);
        chk("reset dut1 outputs", {data_o1[31:2], ready1, error1}, 32'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;

        sel = 1'b0;
        do_txn(32'h10, 4'b1111, 32'hDEAD_BEEF, "w0x10");
        do_txn(32'h10, 4'b0000, 32'h0, "r0x10");
        chk("read value", cur_data, 32'hDEAD_BEEF);
        do_txn(32'h13, 4'b1000, 32'h5555_5555, "wbyte3");
        do_txn(32'h10, 4'b0000, 32'h0, "rmerged");
        chk("merged value", cur_data, 32'h55AD_BEEF);
        do_txn(32'h1000, 4'b1111, 32'h1111_1111, "err0x1000");
        do_txn(32'hFFC, 4'b0000, 32'h0, "rlastword");
        for (int i = 0; i < 4; i++) begin
            a = (32'($urandom_range(64, 1000)) << 2) | 32'($urandom_range(0, 3));
            d = $urandom;
            m = 4'($urandom_range(1, 14));
            do_txn(a, 4'b1111, $urandom, "rnd wfull");
            do_txn(a, m, d, "rnd wpart");
            do_txn(a, 4'b0000, 32'h0, "rnd read");
        end

        // Reset pulsed while the read data is in flight.
        port_address = 32'h10; port_wr = 4'b0; port_enable = 1'b1;
        @(posedge clk); #1;
        chk("rst txn strobe", {31'b0, sen0}, 32'h1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async rst data_o", data_o0, 32'h0);
        chk("async rst flags", {30'b0, ready0, error0}, 32'h0);
        chk("async rst sram", {27'b0, sen0, swe0}, 32'h0);
        port_enable = 1'b0;
        sb.delete();
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        @(negedge clk); rst = 1'b1;
        do_txn(32'h10, 4'b0000, 32'h0, "read after rst");

        sel = 1'b1;
        do_txn(BASE1 + 32'h20, 4'b1111, 32'h1234_5678, "ws3 write");
        do_txn(BASE1 + 32'h20, 4'b0000, 32'h0, "ws3 read");
        do_txn(BASE1 + 32'hFFC, 4'b1111, 32'hCAFE_F00D, "ws3 wlast");
        do_txn(BASE1 + 32'hFFC, 4'b0000, 32'h0, "ws3 rlast");
        do_txn(BASE1 - 32'h4, 4'b0000, 32'h0, "ws3 below base");
        do_txn(BASE1 + 32'h1000, 4'b0001, 32'h0, "ws3 past end");

        // Abort while waiting: enable drops after two wait cycles.
        strobes = 0;
        port_address = BASE1 + 32'h20; port_wr = 4'b0; port_enable = 1'b1;
        @(posedge clk); #1; strobes += int'(sen1);
        @(posedge clk); #1; strobes += int'(sen1);
        @(negedge clk); port_enable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            strobes += int'(sen1);
            if (ready1 || error1) strobes += 100;
        end
        chk("abort no strobe/ready", strobes, 0);
        @(negedge clk);
        do_txn(BASE1 + 32'h20, 4'b0000, 32'h0, "read after abort");

        chk("ready and error together", both_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
